// File: rtl/pipe_main_ctrl.sv
// pipe_main_ctrl
// Registered main-control decode stage between the IF/ID and ID/EX registers.
// The instruction word in ID is decoded into the ID/EX control fields one cycle
// after it is presented. The stage also covers:
//   - load-use stall insertion (with a saturating bubble counter)
//   - branch flush of the ID instruction
//   - sticky trapping of undefined opcodes/functs
//   - a STOP drain/halt state machine
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   id_instr          instruction word in ID
//   id_valid          id_instr holds a real instruction
//   br_flush          taken branch/jump resolved in EX; kill the ID instruction
//   ex_valid          ID/EX holds a real instruction
//   RegWriteEN, Mem2RegSEL, MemWriteEN, Beq, Bne, ALUCtrl, ALUSrc, RegDst,
//   JumpSEL           registered ID/EX control fields
//   pc_hold           combinational; freeze PC and IF/ID this cycle
//   halted            registered; machine stopped after a STOP drain
//   illegal           sticky; an undefined opcode/funct was decoded
//   stall_cnt         saturating count of load-use bubbles
module pipe_main_ctrl #(
    parameter int ALUCTRL_W    = 5,
    parameter int ALUSRC_W     = 3,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          id_instr,
    input  logic                 id_valid,
    input  logic                 br_flush,
    output logic                 ex_valid,
    output logic                 RegWriteEN,
    output logic                 Mem2RegSEL,
    output logic                 MemWriteEN,
    output logic                 Beq,
    output logic                 Bne,
    output logic [ALUCTRL_W-1:0] ALUCtrl,
    output logic [ALUSRC_W-1:0]  ALUSrc,
    output logic [1:0]           RegDst,
    output logic [1:0]           JumpSEL,
    output logic                 pc_hold,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [ALUCTRL_W-1:0] AL_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] AL_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] AL_AND = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] AL_OR  = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] AL_XOR = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] AL_NOR = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] AL_SLT = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] AL_SLL = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] AL_SRL = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] AL_SRA = ALUCTRL_W'(9);

    localparam logic [ALUSRC_W-1:0] SRC_RT    = ALUSRC_W'(0);
    localparam logic [ALUSRC_W-1:0] SRC_ZIMM  = ALUSRC_W'(1);
    localparam logic [ALUSRC_W-1:0] SRC_SIMM  = ALUSRC_W'(2);
    localparam logic [ALUSRC_W-1:0] SRC_RS    = ALUSRC_W'(3);
    localparam logic [ALUSRC_W-1:0] SRC_SHAMT = ALUSRC_W'(4);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_STOP  = 6'd63;

    typedef struct packed {
        logic                 regwr;
        logic                 mem2reg;
        logic                 memwr;
        logic                 beq;
        logic                 bne;
        logic [ALUCTRL_W-1:0] aluctrl;
        logic [ALUSRC_W-1:0]  alusrc;
        logic [1:0]           regdst;
        logic [1:0]           jumpsel;
    } ctrl_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    // Undefined encodings return an all-zero field set with legal=0.
    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn,
                                     output logic legal);
        ctrl_t c;
        c     = '0;
        legal = 1'b1;
        case (op)
            6'd0: begin
                c.regwr  = 1'b1;
                c.regdst = 2'd1;
                case (fn)
                    6'd0:        begin c.aluctrl = AL_SLL; c.alusrc = SRC_SHAMT; end
                    6'd2:        begin c.aluctrl = AL_SRL; c.alusrc = SRC_SHAMT; end
                    6'd3:        begin c.aluctrl = AL_SRA; c.alusrc = SRC_SHAMT; end
                    6'd4:        begin c.aluctrl = AL_SLL; c.alusrc = SRC_RS;    end
                    6'd6:        begin c.aluctrl = AL_SRL; c.alusrc = SRC_RS;    end
                    6'd7:        begin c.aluctrl = AL_SRA; c.alusrc = SRC_RS;    end
                    6'd8: begin
                        c.regwr   = 1'b0;
                        c.regdst  = 2'd0;
                        c.jumpsel = 2'd3;
                    end
                    6'd32, 6'd33: c.aluctrl = AL_ADD;
                    6'd34, 6'd35: c.aluctrl = AL_SUB;
                    6'd36:        c.aluctrl = AL_AND;
                    6'd37:        c.aluctrl = AL_OR;
                    6'd38:        c.aluctrl = AL_XOR;
                    6'd39:        c.aluctrl = AL_NOR;
                    6'd42:        c.aluctrl = AL_SLT;
                    default: begin
                        c     = '0;
                        legal = 1'b0;
                    end
                endcase
            end
            6'd2:  c.jumpsel = 2'd1;
            6'd3: begin
                c.jumpsel = 2'd2;
                c.regwr   = 1'b1;
                c.regdst  = 2'd2;
            end
            6'd4:  begin c.aluctrl = AL_SUB; c.beq = 1'b1; end
            6'd5:  begin c.aluctrl = AL_SUB; c.bne = 1'b1; end
            6'd8, 6'd9: begin c.regwr = 1'b1; c.aluctrl = AL_ADD; c.alusrc = SRC_SIMM; end
            6'd12: begin c.regwr = 1'b1; c.aluctrl = AL_AND; c.alusrc = SRC_ZIMM; end
            6'd13: begin c.regwr = 1'b1; c.aluctrl = AL_OR;  c.alusrc = SRC_ZIMM; end
            6'd14: begin c.regwr = 1'b1; c.aluctrl = AL_XOR; c.alusrc = SRC_ZIMM; end
            6'd35: begin c.regwr = 1'b1; c.mem2reg = 1'b1; c.alusrc = SRC_SIMM; end
            6'd43: begin c.memwr = 1'b1; c.alusrc = SRC_SIMM; end
            6'd63: c = '0;  // STOP is consumed by the FSM, never issued
            default: legal = 1'b0;
        endcase
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [5:0] id_op, id_fn;
    logic [4:0] id_rs, id_rt;
    logic       unused_id_bits;

    assign id_op          = id_instr[31:26];
    assign id_rs          = id_instr[25:21];
    assign id_rt          = id_instr[20:16];
    assign id_fn          = id_instr[5:0];
    assign unused_id_bits = ^id_instr[15:6];

    state_t               state, state_nxt;
    logic [DRN_W-1:0]     drain_cnt, drain_nxt;
    ctrl_t                dec, ctrl_p1;
    logic                 dec_legal;
    logic                 vld_p1;
    logic [4:0]           ex_rt_p1;
    logic [CNT_W-1:0]     stall_cnt_p1;
    logic                 illegal_p1, halted_p1;
    logic                 uses_rt, hazard, hold, stall, load_dec, issue;

    always_comb dec = decode(id_op, id_fn, dec_legal);

    // rt is only a source operand for R-type, branches and stores.
    assign uses_rt = (id_op == OP_RTYPE) | (id_op == OP_BEQ) |
                     (id_op == OP_BNE)   | (id_op == OP_SW);

    assign hazard = vld_p1 & ctrl_p1.mem2reg & (ex_rt_p1 != 5'd0) & id_valid &
                    ((ex_rt_p1 == id_rs) | (uses_rt & (ex_rt_p1 == id_rt)));

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        hold      = 1'b0;
        stall     = 1'b0;
        load_dec  = 1'b0;
        case (state)
            RUN: begin
                if (br_flush) begin
                    hold = 1'b0;
                end else if (hazard) begin
                    hold  = 1'b1;
                    stall = 1'b1;
                end else if (id_valid && id_op == OP_STOP) begin
                    hold      = 1'b1;
                    state_nxt = DRAIN;
                    drain_nxt = DRN_W'(DRAIN_CYCLES - 1);
                end else begin
                    load_dec = id_valid;
                end
            end
            DRAIN: begin
                hold = 1'b1;
                if (drain_cnt == '0) state_nxt = HALT;
                else                 drain_nxt = drain_cnt - DRN_W'(1);
            end
            HALT:    hold = 1'b1;
            default: state_nxt = RUN;
        endcase
    end

    assign issue   = load_dec & dec_legal;
    assign pc_hold = hold & ~reset;

    // ---- ID -> EX stage boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            drain_cnt    <= '0;
            vld_p1       <= 1'b0;
            ctrl_p1      <= '0;
            ex_rt_p1     <= '0;
            stall_cnt_p1 <= '0;
            illegal_p1   <= 1'b0;
            halted_p1    <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            vld_p1    <= issue;
            ctrl_p1   <= issue ? dec : '0;
            ex_rt_p1  <= issue ? id_rt : 5'd0;
            if (stall)
                stall_cnt_p1 <= sat_inc(stall_cnt_p1);
            if (load_dec && !dec_legal)
                illegal_p1 <= 1'b1;
            // Registered off the HALT state, so it rises one edge after entry.
            halted_p1 <= (state == HALT);
        end
    end

    assign ex_valid   = vld_p1;
    assign RegWriteEN = ctrl_p1.regwr;
    assign Mem2RegSEL = ctrl_p1.mem2reg;
    assign MemWriteEN = ctrl_p1.memwr;
    assign Beq        = ctrl_p1.beq;
    assign Bne        = ctrl_p1.bne;
    assign ALUCtrl    = ctrl_p1.aluctrl;
    assign ALUSrc     = ctrl_p1.alusrc;
    assign RegDst     = ctrl_p1.regdst;
    assign JumpSEL    = ctrl_p1.jumpsel;
    assign halted     = halted_p1;
    assign illegal    = illegal_p1;
    assign stall_cnt  = stall_cnt_p1;

endmodule

// File: tb/tb_pipe_main_ctrl.sv
// Directed bench for pipe_main_ctrl (DRAIN_CYCLES=4, CNT_W=4).
module tb_pipe_main_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        br_flush;
    logic        ex_valid, RegWriteEN, Mem2RegSEL, MemWriteEN, Beq, Bne;
    logic [4:0]  ALUCtrl;
    logic [2:0]  ALUSrc;
    logic [1:0]  RegDst, JumpSEL;
    logic        pc_hold, halted, illegal;
    logic [3:0]  stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_main_ctrl #(
        .ALUCTRL_W(5), .ALUSRC_W(3), .DRAIN_CYCLES(4), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
        .br_flush(br_flush), .ex_valid(ex_valid), .RegWriteEN(RegWriteEN),
        .Mem2RegSEL(Mem2RegSEL), .MemWriteEN(MemWriteEN), .Beq(Beq), .Bne(Bne),
        .ALUCtrl(ALUCtrl), .ALUSrc(ALUSrc), .RegDst(RegDst), .JumpSEL(JumpSEL),
        .pc_hold(pc_hold), .halted(halted), .illegal(illegal), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    logic [17:0] ctl;
    assign ctl = {ex_valid, RegWriteEN, Mem2RegSEL, MemWriteEN, Beq, Bne,
                  ALUCtrl, ALUSrc, RegDst, JumpSEL};

    function automatic logic [17:0] ex(input int v, rw, m2r, mw, bq, bn, alu, src, rd, js);
        return {1'(v), 1'(rw), 1'(m2r), 1'(mw), 1'(bq), 1'(bn),
                5'(alu), 3'(src), 2'(rd), 2'(js)};
    endfunction

    function automatic logic [31:0] rtyp(input int rs, rt, rd, sh, fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] ityp(input int op, rs, rt, imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    localparam logic [17:0] BUB = 18'd0;

    initial begin
        logic [17:0] e_add, e_lw, e_lw0;
        int          exp_cnt;
        e_add = ex(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        e_lw  = ex(1, 1, 1, 0, 0, 0, 0, 2, 0, 0);
        e_lw0 = e_lw;

        // Reset with a STOP presented: everything must read zero.
        reset    = 1'b1;
        br_flush = 1'b0;
        id_valid = 1'b1;
        id_instr = ityp(63, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", ctl, BUB);
        chk("rst_pc_hold", pc_hold, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        reset = 1'b0;

        // ADD $3,$1,$2
        id_instr = rtyp(1, 2, 3, 0, 32);
        #1 chk("add_pc_hold", pc_hold, 0);
        cyc();
        chk("add_ctl", ctl, e_add);

        // LW $5 then dependent ADD $6,$5,$2 -> one bubble
        id_instr = ityp(35, 1, 5, 0);
        cyc();
        chk("lw_ctl", ctl, e_lw);
        id_instr = rtyp(5, 2, 6, 0, 32);
        #1 chk("lu_pc_hold", pc_hold, 1);
        cyc();
        chk("lu_bubble", ctl, BUB);
        chk("lu_stall_cnt", stall_cnt, 1);
        #1 chk("lu_release", pc_hold, 0);
        cyc();
        chk("lu_add_issue", ctl, e_add);

        // LW to $0 never stalls
        id_instr = ityp(35, 1, 0, 0);
        cyc();
        chk("lw0_ctl", ctl, e_lw0);
        id_instr = rtyp(0, 2, 6, 0, 32);
        #1 chk("lw0_pc_hold", pc_hold, 0);
        cyc();
        chk("lw0_add", ctl, e_add);
        chk("lw0_stall_cnt", stall_cnt, 1);

        // rt match on SW stalls
        id_instr = ityp(35, 1, 7, 0);
        cyc();
        id_instr = ityp(43, 1, 7, 0);
        #1 chk("sw_pc_hold", pc_hold, 1);
        cyc();
        chk("sw_bubble", ctl, BUB);
        chk("sw_stall_cnt", stall_cnt, 2);
        cyc();
        chk("sw_ctl", ctl, ex(1, 0, 0, 1, 0, 0, 0, 2, 0, 0));

        // rt match on ADDI does not stall (rt is its destination)
        id_instr = ityp(35, 1, 8, 0);
        cyc();
        id_instr = ityp(8, 1, 8, 5);
        #1 chk("addi_pc_hold", pc_hold, 0);
        cyc();
        chk("addi_ctl", ctl, ex(1, 1, 0, 0, 0, 0, 0, 2, 0, 0));

        // BEQ killed by br_flush
        id_instr = ityp(4, 1, 2, 3);
        br_flush = 1'b1;
        #1 chk("flush_pc_hold", pc_hold, 0);
        cyc();
        chk("flush_bubble", ctl, BUB);
        chk("flush_stall_cnt", stall_cnt, 2);
        br_flush = 1'b0;
        cyc();
        chk("beq_ctl", ctl, ex(1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        id_instr = ityp(5, 1, 2, 3);
        cyc();
        chk("bne_ctl", ctl, ex(1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        id_instr = rtyp(0, 2, 3, 4, 3);
        cyc();
        chk("sra_ctl", ctl, ex(1, 1, 0, 0, 0, 0, 9, 4, 1, 0));
        id_instr = rtyp(4, 2, 3, 0, 4);
        cyc();
        chk("sllv_ctl", ctl, ex(1, 1, 0, 0, 0, 0, 7, 3, 1, 0));
        id_instr = rtyp(31, 0, 0, 0, 8);
        cyc();
        chk("jr_ctl", ctl, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 3));
        id_instr = ityp(3, 0, 0, 0);
        cyc();
        chk("jal_ctl", ctl, ex(1, 1, 0, 0, 0, 0, 0, 0, 2, 2));
        id_instr = rtyp(1, 2, 3, 0, 42);
        cyc();
        chk("slt_ctl", ctl, ex(1, 1, 0, 0, 0, 0, 6, 0, 1, 0));

        // Illegal opcode then ORI
        id_instr = ityp(20, 1, 2, 3);
        cyc();
        chk("ill_bubble", ctl, BUB);
        chk("ill_flag", illegal, 1);
        id_instr = ityp(13, 1, 2, 7);
        cyc();
        chk("ori_ctl", ctl, ex(1, 1, 0, 0, 0, 0, 3, 1, 0, 0));
        chk("ill_sticky", illegal, 1);
        id_instr = rtyp(1, 2, 3, 0, 1);
        cyc();
        chk("ill_funct_bubble", ctl, BUB);

        // Flush beats a load-use hazard
        id_instr = ityp(35, 1, 9, 0);
        cyc();
        id_instr = rtyp(9, 2, 6, 0, 32);
        br_flush = 1'b1;
        #1 chk("flush_hz_pc_hold", pc_hold, 0);
        cyc();
        chk("flush_hz_bubble", ctl, BUB);
        chk("flush_hz_stall_cnt", stall_cnt, 2);
        br_flush = 1'b0;

        // Saturation of the 4-bit stall counter
        exp_cnt = 2;
        for (int i = 0; i < 19; i++) begin
            id_instr = ityp(35, 1, 5, 0);
            cyc();
            id_instr = rtyp(5, 2, 6, 0, 32);
            cyc();
            exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
            chk($sformatf("sat_cnt_%0d", i), stall_cnt, exp_cnt);
        end

        // STOP: drain then halt 5 edges later
        id_instr = ityp(63, 0, 0, 0);
        #1 chk("stop_pc_hold", pc_hold, 1);
        cyc();
        chk("stop_bubble", ctl, BUB);
        id_instr = rtyp(1, 2, 3, 0, 32);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk($sformatf("drain_halted_%0d", k), halted, (k == 5) ? 1 : 0);
            chk($sformatf("drain_pc_hold_%0d", k), pc_hold, 1);
            chk($sformatf("drain_ctl_%0d", k), ctl, BUB);
        end
        repeat (2) cyc();
        chk("halt_sticky", halted, 1);

        // Asynchronous reset mid-cycle from HALT
        #3 reset = 1'b1;
        #1;
        chk("arst_halted", halted, 0);
        chk("arst_pc_hold", pc_hold, 0);
        chk("arst_illegal", illegal, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
        cyc();
        reset = 1'b0;

        // Reset during DRAIN returns to RUN
        id_instr = ityp(63, 0, 0, 0);
        cyc();
        id_valid = 1'b0;
        #1 chk("drain2_pc_hold", pc_hold, 1);
        repeat (2) cyc();
        #2 reset = 1'b1;
        #1 chk("drain_rst_pc_hold", pc_hold, 0);
        cyc();
        reset    = 1'b0;
        id_valid = 1'b1;
        id_instr = rtyp(1, 2, 3, 0, 32);
        #1 chk("post_rst_pc_hold", pc_hold, 0);
        cyc();
        chk("post_rst_add", ctl, e_add);
        id_valid = 1'b0;
        repeat (6) cyc();
        chk("post_rst_halted", halted, 0);
        chk("idle_bubble", ctl, BUB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_main_ctrl.md
# pipe_main_ctrl

Registered main-control decode stage for the pipelined CPU. It sits between the IF/ID and ID/EX registers and decodes the instruction word into the ID/EX control fields, one cycle after it is presented. It adds what the combinational decoder lacked:
- load-use hazard stall insertion;
- branch flush;
- illegal-instruction trapping;
- a STOP drain/halt state machine;
- a saturating stall counter.

## Interface
Parameters:
- ALUCTRL_W, 5, width of ALUCtrl
- ALUSRC_W, 3, width of ALUSrc
- DRAIN_CYCLES, 4, bubble cycles after STOP before halted rises (≥1)
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- id_instr  in  32  instruction in ID
- id_valid  in  1  id_instr holds a real instruction
- br_flush  in  1  branch/jump resolved taken in EX; kill the ID instruction
- ex_valid  out  1  ID/EX holds a real instruction
- RegWriteEN, Mem2RegSEL, MemWriteEN, Beq, Bne  out  1 each  registered control
- ALUCtrl  out  ALUCTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sll, 8 srl, 9 sra
- ALUSrc  out  ALUSRC_W  0 rt, 1 zero-ext imm, 2 sign-ext imm, 3 rs as shift amount, 4 shamt
- RegDst  out  2  0 rt, 1 rd, 2 $31
- JumpSEL  out  2  0 none, 1 j, 2 jal, 3 jr
- pc_hold  out  1  combinational; freeze PC and IF/ID this cycle
- halted  out  1  registered; the machine is stopped
- illegal  out  1  sticky; an undefined opcode/funct was decoded
- stall_cnt  out  CNT_W  saturating count of load-use bubbles

## Operation
Opcodes:
- R-type 0
- J 2, JAL 3, BEQ 4, BNE 5
- ADDI 8, ADDIU 9, ANDI 12, ORI 13, XORI 14
- LW 35, SW 43, STOP 63

R-type funct codes: SLL 0, SRL 2, SRA 3, SLLV 4, SRLV 6, SRAV 7, JR 8, ADD/ADDU 32/33, SUB/SUBU 34/35, AND 36, OR 37, XOR 38, NOR 39, SLT 42.

Decoded fields:
- R-type ALU ops: RegWriteEN=1, RegDst=1; ALUSrc=4 for the immediate-shift group, 3 for the variable-shift group, 0 for all others.
- JR: RegWriteEN=0, JumpSEL=3.
- BEQ/BNE: ALUCtrl=1, ALUSrc=0, and Beq or Bne =1.
- Immediate ops: RegWriteEN=1, RegDst=0. ALUSrc=2 for ADDI/ADDIU, 1 for ANDI/ORI/XORI.
- LW: RegWriteEN=1, Mem2RegSEL=1, ALUSrc=2.
- SW: MemWriteEN=1, ALUSrc=2.
- J: JumpSEL=1.
- JAL: JumpSEL=2, RegWriteEN=1, RegDst=2.
- Any field not listed for an instruction is 0.

Bubbles and illegal instructions:
- A bubble means all control outputs are 0, including ex_valid.
- An undefined opcode or funct is loaded as a bubble and sets illegal. illegal clears only on reset.

Load-use hazard:
- Internal state: ex_rt, the rt field of the instruction now in EX.
- Hazard when ex_valid & Mem2RegSEL & ex_rt≠0 & id_valid, and ex_rt equals either:
  - the ID rs field, or
  - the ID rt field, when ID is R-type, BEQ, BNE or SW.
- On a hazard: load a bubble, set pc_hold=1, increment stall_cnt (saturate at all-ones).

FSM states: RUN, DRAIN, HALT.
- RUN, per-cycle priority:
  1. br_flush: bubble, pc_hold=0.
  2. Hazard: as above.
  3. id_valid & STOP: bubble, pc_hold=1, load the drain counter with DRAIN_CYCLES-1, go to DRAIN.
  4. Otherwise: load the decoded fields, pc_hold=0.
- DRAIN: bubble, pc_hold=1, decrement the counter. When the counter is 0, go to HALT.
- HALT: bubble, pc_hold=1, halted=1. Leave only on reset.
- A STOP coincident with br_flush is killed and the FSM stays in RUN.

## Timing
- Decode latency 1 cycle: id_instr at edge N appears on the ex_* outputs after edge N+1.
- Hazard bubble lasts exactly 1 cycle; the held instruction decodes on the next cycle.
- pc_hold is combinational, valid in the same cycle as the hazard/STOP/DRAIN/HALT condition.
- halted rises DRAIN_CYCLES+1 edges after the edge that samples STOP.
- Reset (asynchronous, mid-operation included):
  - all outputs 0, ex_rt=0, stall_cnt=0, illegal=0, FSM=RUN;
  - pc_hold=0 while reset is asserted.

## Test plan
- ADD $3,$1,$2 (funct 32), id_valid=1 -> next cycle: ex_valid=1, RegWriteEN=1, RegDst=1, ALUCtrl=0, ALUSrc=0; pc_hold=0.
- LW $5,0($1) then ADD $6,$5,$2 -> pc_hold=1 for one cycle, bubble in EX, ADD issued the following cycle, stall_cnt=1. The same sequence with LW to $0 -> no stall.
- BEQ issued with br_flush=1 in the same cycle -> EX gets a bubble, pc_hold=0, stall_cnt unchanged.
- Opcode 6'd20 -> bubble and illegal=1. A following ORI decodes normally (ALUCtrl=3, ALUSrc=1) and illegal stays 1.
- STOP with DRAIN_CYCLES=4 -> pc_hold=1 from that cycle on, halted=1 exactly 5 edges later, all control outputs 0. Reset asserted during DRAIN -> FSM returns to RUN and halted stays 0.
- Force 2^CNT_W+3 load-use stalls (CNT_W=4 in the bench) -> stall_cnt saturates at 15.
